// File: rtl/logit_collect_10_bf16.sv
// Collects ten bfloat16 logit beats into a registered bank for the max-find stage.
// Short frames are padded with PAD_VALUE; short or over-long frames raise a sticky len_err.
module logit_collect_10_bf16 #(
    parameter logic [15:0] PAD_VALUE   = 16'hFF80,
    parameter int          FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [15:0]            in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [15:0]            logit_0,
    output logic [15:0]            logit_1,
    output logic [15:0]            logit_2,
    output logic [15:0]            logit_3,
    output logic [15:0]            logit_4,
    output logic [15:0]            logit_5,
    output logic [15:0]            logit_6,
    output logic [15:0]            logit_7,
    output logic [15:0]            logit_8,
    output logic [15:0]            logit_9,
    output logic                   bank_valid,
    input  logic                   bank_ready,
    output logic                   len_err,
    input  logic                   clr_err,
    output logic [3:0]             fill_cnt,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] bank [10];

    logic accept;
    logic at_last_slot;
    logic frame_end;
    logic short_end;
    logic set_err;
    logic release_bank;

    assign in_ready     = (state == FILL);
    assign bank_valid   = (state == HOLD);

    assign accept       = in_valid && in_ready;
    assign at_last_slot = (fill_cnt == 4'd9);
    assign frame_end    = accept && (in_last || at_last_slot);
    assign short_end    = accept && in_last && !at_last_slot;
    // A frame is malformed if it ends early or runs past slot 9 without in_last.
    assign set_err      = short_end || (accept && !in_last && at_last_slot);
    assign release_bank = bank_valid && bank_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL: if (frame_end)    next_state = HOLD;
            HOLD: if (release_bank) next_state = FILL;
            default:                next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt <= 4'd0;
        end else if (accept) begin
            fill_cnt <= frame_end ? 4'd0 : fill_cnt + 4'd1;
        end
    end

    // Slot fill_cnt takes the beat; on an early in_last every later slot is padded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 10; i++) begin
                bank[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (accept && (4'(i) == fill_cnt)) begin
                    bank[i] <= in_data;
                end else if (short_end && (4'(i) > fill_cnt)) begin
                    bank[i] <= PAD_VALUE;
                end
            end
        end
    end

    // A new error on the same edge as clr_err takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_err <= 1'b0;
        end else if (set_err) begin
            len_err <= 1'b1;
        end else if (clr_err) begin
            len_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (release_bank) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign logit_0 = bank[0];
    assign logit_1 = bank[1];
    assign logit_2 = bank[2];
    assign logit_3 = bank[3];
    assign logit_4 = bank[4];
    assign logit_5 = bank[5];
    assign logit_6 = bank[6];
    assign logit_7 = bank[7];
    assign logit_8 = bank[8];
    assign logit_9 = bank[9];

endmodule

// File: tb/tb_logit_collect_10_bf16.sv
// Directed bench for logit_collect_10_bf16 with hand-computed expected values.
module tb_logit_collect_10_bf16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [15:0] logit_0, logit_1, logit_2, logit_3, logit_4;
    logic [15:0] logit_5, logit_6, logit_7, logit_8, logit_9;
    logic        bank_valid;
    logic        bank_ready;
    logic        len_err;
    logic        clr_err;
    logic [3:0]  fill_cnt;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad   = 0;

    logit_collect_10_bf16 #(
        .PAD_VALUE  (16'hFF80),
        .FRAME_CNT_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .logit_0   (logit_0),
        .logit_1   (logit_1),
        .logit_2   (logit_2),
        .logit_3   (logit_3),
        .logit_4   (logit_4),
        .logit_5   (logit_5),
        .logit_6   (logit_6),
        .logit_7   (logit_7),
        .logit_8   (logit_8),
        .logit_9   (logit_9),
        .bank_valid(bank_valid),
        .bank_ready(bank_ready),
        .len_err   (len_err),
        .clr_err   (clr_err),
        .fill_cnt  (fill_cnt),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] get_logit(input int idx);
        case (idx)
            0: return logit_0;
            1: return logit_1;
            2: return logit_2;
            3: return logit_3;
            4: return logit_4;
            5: return logit_5;
            6: return logit_6;
            7: return logit_7;
            8: return logit_8;
            default: return logit_9;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        step();
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_in_ready"},   32'(in_ready),   32'd1);
        check_output({tag, "_bank_valid"}, 32'(bank_valid), 32'd0);
        check_output({tag, "_fill_cnt"},   32'(fill_cnt),   32'd0);
        check_output({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
        check_output({tag, "_len_err"},    32'(len_err),    32'd0);
        for (int i = 0; i < 10; i++) begin
            check_output($sformatf("%s_logit%0d", tag, i), 32'(get_logit(i)), 32'd0);
        end
    endtask

    task automatic release_step();
        bank_ready = 1'b1;
        step();
        bank_ready = 1'b0;
    endtask

    logic [15:0] one_to_ten [10];

    initial begin
        one_to_ten = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0,
                       16'h40C0, 16'h40E0, 16'h4100, 16'h4110, 16'h4120};
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'h0000;
        in_last    = 1'b0;
        bank_ready = 1'b0;
        clr_err    = 1'b0;
        step();
        step();
        check_reset_values("rst");
        reset = 1'b1;
        step();

        // Normal ten-beat frame, then hold for 20 cycles with ignored beats
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, one_to_ten[i], i == 9);
            if (i < 9) check_output($sformatf("fill_%0d", i), 32'(fill_cnt), 32'(i + 1));
        end
        in_valid = 1'b0;
        check_output("full_bank_valid", 32'(bank_valid), 32'd1);
        check_output("full_in_ready",   32'(in_ready),   32'd0);
        check_output("full_fill_cnt",   32'(fill_cnt),   32'd0);
        check_output("full_logit0",     32'(logit_0),    32'h3F80);
        check_output("full_logit9",     32'(logit_9),    32'h4120);
        check_output("full_len_err",    32'(len_err),    32'd0);
        for (int k = 0; k < 20; k++) apply_stimulus(1'b1, 16'hDEAD, 1'b1);
        in_valid = 1'b0;
        check_output("hold_bank_valid", 32'(bank_valid), 32'd1);
        check_output("hold_logit0",     32'(logit_0),    32'h3F80);
        check_output("hold_logit4",     32'(logit_4),    32'h40A0);
        check_output("hold_fill_cnt",   32'(fill_cnt),   32'd0);

        release_step();
        check_output("rel_frame_cnt",  32'(frame_cnt),  32'd1);
        check_output("rel_in_ready",   32'(in_ready),   32'd1);
        check_output("rel_bank_valid", 32'(bank_valid), 32'd0);
        check_output("rel_keep_logit", 32'(logit_9),    32'h4120);

        // bank_ready in FILL must not count a release
        release_step();
        check_output("fill_rdy_frame_cnt", 32'(frame_cnt), 32'd1);

        // Short frame of four beats, pad the rest
        apply_stimulus(1'b1, 16'h1111, 1'b0);
        apply_stimulus(1'b1, 16'h2222, 1'b0);
        apply_stimulus(1'b1, 16'h3333, 1'b0);
        apply_stimulus(1'b1, 16'h4040, 1'b1);
        in_valid = 1'b0;
        check_output("short_logit0",     32'(logit_0),    32'h1111);
        check_output("short_logit3",     32'(logit_3),    32'h4040);
        for (int i = 4; i < 10; i++) begin
            check_output($sformatf("short_pad%0d", i), 32'(get_logit(i)), 32'hFF80);
        end
        check_output("short_len_err",    32'(len_err),    32'd1);
        check_output("short_bank_valid", 32'(bank_valid), 32'd1);
        release_step();
        check_output("short_frame_cnt",  32'(frame_cnt),  32'd2);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_output("clr_len_err", 32'(len_err), 32'd0);

        // Ten beats without in_last, then an eleventh beat held off
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 16'(16'h5000 + i), 1'b0);
        check_output("long_bank_valid", 32'(bank_valid), 32'd1);
        check_output("long_len_err",    32'(len_err),    32'd1);
        check_output("long_logit9",     32'(logit_9),    32'h5009);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        check_output("long_11th_ready", 32'(in_ready), 32'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_output("long_11th_fill",  32'(fill_cnt), 32'd0);
        check_output("long_11th_logit", 32'(logit_0),  32'h5000);
        check_output("long_clr_err",    32'(len_err),  32'd0);

        // Release with a beat already pending: it is taken only on the following edge
        in_data = 16'h7777;
        in_last = 1'b1;
        release_step();
        check_output("pend_frame_cnt", 32'(frame_cnt), 32'd3);
        check_output("pend_fill_cnt",  32'(fill_cnt),  32'd0);
        check_output("pend_logit0",    32'(logit_0),   32'h5000);
        clr_err = 1'b1;
        step();
        clr_err  = 1'b0;
        in_valid = 1'b0;
        check_output("set_wins_len_err", 32'(len_err),    32'd1);
        check_output("pend_logit0_new",  32'(logit_0),    32'h7777);
        check_output("pend_logit1_pad",  32'(logit_1),    32'hFF80);
        check_output("pend_bank_valid",  32'(bank_valid), 32'd1);
        release_step();
        check_output("pend_rel_frame_cnt", 32'(frame_cnt), 32'd4);

        // Reset in the middle of a frame
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 16'(16'h9000 + i), 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        reset = 1'b1;
        step();
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 16'(16'h6000 + i), i == 9);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_output($sformatf("post_rst_logit%0d", i), 32'(get_logit(i)), 32'(16'h6000 + i));
        end
        check_output("post_rst_len_err", 32'(len_err), 32'd0);

        // Reset while holding, then three back-to-back frames at full rate
        reset = 1'b0;
        #1;
        check_output("hold_rst_bank_valid", 32'(bank_valid), 32'd0);
        step();
        reset      = 1'b1;
        step();
        bank_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 11; k++) begin
                apply_stimulus(1'b1, 16'(16'h8000 + k), k == 9);
                if (k == 9)  check_output($sformatf("tp_f%0d_valid", f), 32'(bank_valid), 32'd1);
                if (k == 10) check_output($sformatf("tp_f%0d_ready", f), 32'(in_ready),   32'd1);
            end
        end
        in_valid   = 1'b0;
        bank_ready = 1'b0;
        check_output("tp_frame_cnt",  32'(frame_cnt), 32'd3);
        check_output("tp_logit9",     32'(logit_9),   32'h8009);
        check_output("tp_fill_cnt",   32'(fill_cnt),  32'd0);
        check_output("tp_len_err",    32'(len_err),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
